// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite encodings, sequencer FSM states and default LED register address
package ahb_pkg;
  typedef enum logic [2:0] {IDLE, ADDR, DATA, WAIT, RADDR, RDATA} seq_state_e;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [31:0] GPIO_ADDR_DEF = 32'h5000_0000;
  function automatic logic [23:0] at_least_one(input logic [23:0] v);
    return (v == '0) ? 24'd1 : v;
  endfunction
endpackage

// File: rtl/ahb_led_sequencer_if.sv
// ahb_led_sequencer_if: AHB-Lite single-master bus between the sequencer and its slave
interface ahb_led_sequencer_if #(parameter int W = 32);
  logic [W-1:0] HADDR;
  logic [1:0] HTRANS;
  logic HWRITE;
  logic [2:0] HSIZE;
  logic [2:0] HBURST;
  logic [W-1:0] HWDATA;
  logic [W-1:0] HRDATA;
  logic HREADY;
  logic HRESP;
  modport master (output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, input HRDATA, HREADY, HRESP);
  modport slave (input HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, output HRDATA, HREADY, HRESP);
endinterface

// File: rtl/seq_interval_timer.sv
// seq_interval_timer: loadable down-counter flagging the last cycle of a wait interval
module seq_interval_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        dec,
  input  logic [23:0] load_val,
  output logic        expire
);
  logic [23:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (dec && cnt_q != '0) ? cnt_q - 24'd1 : cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign expire = cnt_q == 24'd1;
endmodule

// File: rtl/ahb_led_sequencer.sv
// ahb_led_sequencer: AHB-Lite master writing a 4-bit LED pattern table to GPIO; SEQ_READBACK_EN adds a read-verify per step
module ahb_led_sequencer
  import ahb_pkg::*;
#(
  parameter int W = 32,
  parameter int N_STEPS = 8,
  parameter logic [W-1:0] GPIO_ADDR = W'(GPIO_ADDR_DEF)
) (
  input  logic                       HCLK,
  input  logic                       HRESET,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       loop,
  input  logic [23:0]                interval,
  input  logic                       pat_we,
  input  logic [$clog2(N_STEPS)-1:0] pat_idx,
  input  logic [3:0]                 pat_data,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [$clog2(N_STEPS)-1:0] step_idx,
  ahb_led_sequencer_if.master        bus
);
  localparam int SW = $clog2(N_STEPS);
  seq_state_e state_q, state_d;
  logic [SW-1:0] step_q, step_d;
  logic [3:0] tbl_q [N_STEPS];
  logic [3:0] tbl_d [N_STEPS];
  logic err_q, err_d, done_q, done_d, pend_q, pend_d;
  logic load, expire, addr_ph, hrdata_unused;
  logic [3:0] cur;
  assign cur = tbl_q[step_q];
  assign hrdata_unused = ^bus.HRDATA;
  seq_interval_timer u_timer (
    .clk(HCLK),
    .rst(HRESET),
    .load(load),
    .dec(state_q == WAIT),
    .load_val(at_least_one(interval)),
    .expire(expire)
  );
  always_comb begin
    state_d = state_q;
    step_d = step_q;
    err_d = err_q;
    done_d = 1'b0;
    load = 1'b0;
    tbl_d = tbl_q;
    if (state_q == IDLE && pat_we) tbl_d[pat_idx] = pat_data;
    case (state_q)
      IDLE: if (start) begin
        state_d = ADDR;
        step_d = '0;
        err_d = 1'b0;
      end
      ADDR: if (bus.HREADY) state_d = DATA;
      DATA: if (bus.HRESP) begin
        err_d = 1'b1;
        state_d = IDLE;
      end else if (bus.HREADY) begin
`ifdef SEQ_READBACK_EN
        state_d = RADDR;
`else
        state_d = WAIT;
        load = 1'b1;
`endif
      end
`ifdef SEQ_READBACK_EN
      RADDR: if (bus.HREADY) state_d = RDATA;
      RDATA: if (bus.HRESP || (bus.HREADY && bus.HRDATA[3:0] != cur)) begin
        err_d = 1'b1;
        state_d = IDLE;
      end else if (bus.HREADY) begin
        state_d = WAIT;
        load = 1'b1;
      end
`endif
      // a pending stop wins over the interval expiring in the same cycle
      WAIT: if (pend_q) state_d = IDLE;
      else if (expire) begin
        if (step_q == SW'(N_STEPS - 1) && !loop) begin
          state_d = IDLE;
          done_d = 1'b1;
        end else begin
          step_d = step_q + 1'b1;
          state_d = ADDR;
        end
      end
      default: state_d = IDLE;
    endcase
    pend_d = state_q != IDLE && state_d != IDLE && (pend_q || stop);
  end
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= IDLE;
      step_q <= '0;
      err_q <= 1'b0;
      done_q <= 1'b0;
      pend_q <= 1'b0;
      tbl_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      step_q <= step_d;
      err_q <= err_d;
      done_q <= done_d;
      pend_q <= pend_d;
      tbl_q <= tbl_d;
    end
  end
  assign addr_ph = state_q == ADDR || state_q == RADDR;
  assign bus.HTRANS = addr_ph ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.HADDR = addr_ph ? GPIO_ADDR : '0;
  assign bus.HWRITE = state_q == ADDR;
  assign bus.HSIZE = HSIZE_WORD;
  assign bus.HBURST = HBURST_SINGLE;
  assign bus.HWDATA = (state_q == DATA) ? W'(cur) : '0;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign err = err_q;
  assign step_idx = step_q;
endmodule

// File: tb/tb_ahb_led_sequencer.sv
// tb_ahb_led_sequencer: directed scoreboard bench with a wait-state/error-capable AHB slave model
module tb_ahb_led_sequencer;
`ifdef SEQ_READBACK_EN
  localparam int RB = 2;
`else
  localparam int RB = 0;
`endif
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int ta;
    int td;
  } beat_t;

  logic clk = 1'b0;
  logic HRESET, start, stop, loop, pat_we;
  logic [23:0] interval;
  logic [2:0] pat_idx;
  logic [3:0] pat_data;
  logic busy, done, err;
  logic [2:0] step_idx;

  ahb_led_sequencer_if #(.W(32)) bus ();

  ahb_led_sequencer #(.W(32), .N_STEPS(8), .GPIO_ADDR(32'h5000_0000)) dut (
    .HCLK(clk),
    .HRESET(HRESET),
    .start(start),
    .stop(stop),
    .loop(loop),
    .interval(interval),
    .pat_we(pat_we),
    .pat_idx(pat_idx),
    .pat_data(pat_data),
    .busy(busy),
    .done(done),
    .err(err),
    .step_idx(step_idx),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // slave: ws wait states per data phase, optional error on one step, mirrors last written LED value
  logic dph = 1'b0, a_wr = 1'b0, err_en = 1'b0, corrupt = 1'b0;
  logic [31:0] a_addr = '0;
  logic [3:0] gpio = '0;
  int wcnt = 0, ws = 0, err_step = 0;
  assign bus.HREADY = !(dph && wcnt != 0);
  assign bus.HRESP = dph && bus.HREADY && a_wr && err_en && (int'(step_idx) == err_step);
  assign bus.HRDATA = {28'h0, (corrupt && gpio == 4'h4) ? 4'h5 : gpio};

  always @(posedge clk) begin
    if (HRESET) begin
      dph <= 1'b0;
      wcnt <= 0;
      gpio <= '0;
    end else if (bus.HREADY) begin
      if (dph && a_wr && !bus.HRESP) gpio <= bus.HWDATA[3:0];
      dph <= bus.HTRANS == 2'b10;
      a_wr <= bus.HWRITE;
      a_addr <= bus.HADDR;
      wcnt <= ws;
    end else wcnt <= wcnt - 1;
  end

  beat_t obs[$];
  logic [31:0] exp_q[$];
  int cyc = 0, last_ta = 0, done_cnt = 0, hold_bad = 0, stall_cnt = 0, ns_cnt = 0;
  logic stall_prev = 1'b0;
  logic [31:0] prev_wd = '0;
  logic [2:0] prev_step = '0;

  always @(negedge clk) begin
    beat_t nb;
    cyc++;
    if (bus.HTRANS == 2'b10) begin
      ns_cnt++;
      if (bus.HWRITE) last_ta = cyc;
    end
    if (dph && bus.HREADY && a_wr && !bus.HRESP) begin
      nb.addr = a_addr;
      nb.data = bus.HWDATA;
      nb.ta = last_ta;
      nb.td = cyc;
      obs.push_back(nb);
    end
    if (done) done_cnt++;
    if (dph && a_wr) begin
      if (stall_prev && (bus.HWDATA !== prev_wd || step_idx !== prev_step)) hold_bad++;
      if (!bus.HREADY) stall_cnt++;
      stall_prev = !bus.HREADY;
      prev_wd = bus.HWDATA;
      prev_step = step_idx;
    end else stall_prev = 1'b0;
  end

  int n_chk = 0, n_err = 0;
  logic [3:0] mt [8];

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  task automatic prog(input int i, input logic [3:0] v);
    pat_we = 1'b1;
    pat_idx = 3'(i);
    pat_data = v;
    step();
    pat_we = 1'b0;
    mt[i] = v;
  endtask

  task automatic pulse_start(input logic with_stop);
    start = 1'b1;
    stop = with_stop;
    step();
    start = 1'b0;
    stop = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 1000) begin
      step();
      k++;
    end
    chk({tag, "_idle"}, 64'(busy), 64'(0));
  endtask

  task automatic run_seq(input string tag, input int n, input logic [23:0] iv, input logic with_stop, input logic poke);
    int pt = -1;
    beat_t b;
    logic [31:0] e;
    interval = iv;
    for (int k = 0; k < n; k++) exp_q.push_back({28'h0, mt[k % 8]});
    pulse_start(with_stop);
    if (poke) begin
      repeat (10) step();
      start = 1'b1;
      pat_we = 1'b1;
      pat_idx = 3'd0;
      pat_data = 4'hf;
      step();
      start = 1'b0;
      pat_we = 1'b0;
    end
    wait_idle(tag);
    chk({tag, "_beats"}, 64'(obs.size()), 64'(n));
    while (obs.size() > 0 && exp_q.size() > 0) begin
      b = obs.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_data"}, 64'(b.data), 64'(e));
      chk({tag, "_addr"}, 64'(b.addr), 64'(32'h5000_0000));
      if (pt >= 0) chk({tag, "_gap"}, 64'(b.ta - pt - 1), 64'((iv == 0 ? 1 : int'(iv)) + RB));
      pt = b.td;
    end
    obs.delete();
    exp_q.delete();
  endtask

  initial begin
    int d0, h0, s0, ns0, k, pt;
    beat_t b;
    HRESET = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    loop = 1'b0;
    pat_we = 1'b0;
    pat_idx = '0;
    pat_data = '0;
    interval = '0;
    repeat (3) step();
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_step", 64'(step_idx), 64'(0));
    chk("rst_htrans", 64'(bus.HTRANS), 64'(0));
    chk("rst_haddr", 64'(bus.HADDR), 64'(0));
    chk("rst_hwdata", 64'(bus.HWDATA), 64'(0));
    chk("rst_hwrite", 64'(bus.HWRITE), 64'(0));
    HRESET = 1'b0;
    step();
    foreach (mt[i]) mt[i] = 4'h0;
    d0 = done_cnt;
    run_seq("zero", 8, 24'd0, 1'b0, 1'b0);
    chk("zero_done", 64'(done_cnt - d0), 64'(1));
    for (int i = 0; i < 8; i++) prog(i, 4'(1 << (i % 4)));
    d0 = done_cnt;
    run_seq("walk", 8, 24'd3, 1'b0, 1'b1);
    chk("walk_done", 64'(done_cnt - d0), 64'(1));
    ws = 2;
    h0 = hold_bad;
    s0 = stall_cnt;
    d0 = done_cnt;
    run_seq("wstate", 8, 24'd3, 1'b0, 1'b0);
    chk("wstate_hold", 64'(hold_bad), 64'(h0));
    chk("wstate_stalls", 64'(stall_cnt - s0), 64'(16));
    chk("wstate_done", 64'(done_cnt - d0), 64'(1));
    ws = 0;
    interval = 24'd5;
    d0 = done_cnt;
    exp_q.push_back({28'h0, mt[0]});
    exp_q.push_back({28'h0, mt[1]});
    pulse_start(1'b0);
    k = 0;
    while (!(dph && a_wr && step_idx == 3'd1) && k < 100) begin
      step();
      k++;
    end
    chk("stop_reach", 64'(step_idx), 64'(1));
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_wait", 64'(busy), 64'(1));
    repeat (1 + RB) step();
    chk("stop_halt", 64'(busy), 64'(0));
    wait_idle("stop");
    chk("stop_done", 64'(done_cnt - d0), 64'(0));
    chk("stop_beats", 64'(obs.size()), 64'(2));
    for (int j = 0; j < 2; j++)
      if (obs.size() > 0 && exp_q.size() > 0) begin
        b = obs.pop_front();
        chk("stop_data", 64'(b.data), 64'(exp_q.pop_front()));
      end
    obs.delete();
    exp_q.delete();
    err_en = 1'b1;
    err_step = 2;
    d0 = done_cnt;
    run_seq("hresp", 2, 24'd1, 1'b0, 1'b0);
    chk("hresp_err", 64'(err), 64'(1));
    chk("hresp_done", 64'(done_cnt - d0), 64'(0));
    ns0 = ns_cnt;
    repeat (10) step();
    chk("hresp_quiet", 64'(ns_cnt - ns0), 64'(0));
    chk("hresp_sticky", 64'(err), 64'(1));
    err_en = 1'b0;
    pulse_start(1'b0);
    chk("hresp_clear", 64'(err), 64'(0));
    wait_idle("hresp_rerun");
    obs.delete();
    d0 = done_cnt;
    run_seq("startstop", 8, 24'd2, 1'b1, 1'b0);
    chk("startstop_done", 64'(done_cnt - d0), 64'(1));
    for (int i = 0; i < 8; i++) prog(i, 4'(i + 3));
    loop = 1'b1;
    interval = 24'd0;
    for (int j = 0; j < 40; j++) exp_q.push_back({28'h0, mt[j % 8]});
    pulse_start(1'b0);
    k = 0;
    while (obs.size() < 24 && k < 500) begin
      step();
      k++;
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    loop = 1'b0;
    wait_idle("loop");
    chk("loop_enough", 64'(obs.size() >= 24), 64'(1));
    pt = -1;
    while (obs.size() > 0 && exp_q.size() > 0) begin
      b = obs.pop_front();
      chk("loop_data", 64'(b.data), 64'(exp_q.pop_front()));
      if (pt >= 0) chk("loop_period", 64'(b.ta - pt), 64'(3 + RB));
      pt = b.ta;
    end
    obs.delete();
    exp_q.delete();
`ifdef SEQ_READBACK_EN
    prog(0, 4'h4);
    corrupt = 1'b1;
    interval = 24'd1;
    pulse_start(1'b0);
    wait_idle("rb");
    chk("rb_err", 64'(err), 64'(1));
    chk("rb_busy", 64'(busy), 64'(0));
    chk("rb_beats", 64'(obs.size()), 64'(1));
    corrupt = 1'b0;
    obs.delete();
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
